// File: rtl/graphics_pipe.sv
// graphics_pipe: three-stage text-mode pixel renderer.
// Stage 1 registers the pixel and addresses the external font ROM.
// Stage 2 captures the ROM dot, applies blink/cursor and reads the palette.
// Stage 3 registers the video word and the delayed display enable.
// The pipeline has no handshake: one pixel enters and one leaves every clock.
module graphics_pipe #(
  parameter int CHAR_W       = 5,
  parameter int ATTR_W       = 2,
  parameter int COLOR_W      = 6,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 8,
  parameter int CURSOR_H     = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_de,
  input  logic [9:0]                 i_x,
  input  logic [9:0]                 i_y,
  input  logic [CHAR_W-1:0]          i_char,
  input  logic [ATTR_W-1:0]          i_attr,
  input  logic                       i_blink,
  input  logic                       i_cursor,
  input  logic                       i_frame,
  input  logic                       i_pal_we,
  input  logic [ATTR_W-1:0]          i_pal_addr,
  input  logic [2*COLOR_W-1:0]       i_pal_data,
  output logic [CHAR_W-1:0]          o_rom_char,
  output logic [$clog2(GLYPH_H)-1:0] o_rom_row,
  output logic [$clog2(GLYPH_W)-1:0] o_rom_col,
  input  logic                       i_rom_dot,
  output logic [COLOR_W-1:0]         o_video,
  output logic                       o_de
);

  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int COL_W = $clog2(GLYPH_W);
  localparam int PAL_N = 2 ** ATTR_W;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [ROW_W-1:0] CUR_ROW  = ROW_W'(GLYPH_H - CURSOR_H);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Reset contents of one palette entry, packed as {fg, bg}.
  function automatic logic [2*COLOR_W-1:0] pal_default(input int idx);
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    case (idx)
      0:       begin fg = COLOR_W'(6'b111111); bg = COLOR_W'(6'b000000); end
      1:       begin fg = COLOR_W'(6'b000000); bg = COLOR_W'(6'b011101); end
      2:       begin fg = COLOR_W'(6'b000000); bg = COLOR_W'(6'b110001); end
      3:       begin fg = COLOR_W'(6'b000000); bg = COLOR_W'(6'b000000); end
      default: begin fg = '1;                  bg = '0;                  end
    endcase
    return {fg, bg};
  endfunction

  // Glyph-relative coordinates: sizes are powers of two, so mod is a bit slice.
  logic [COL_W-1:0] cx;
  logic [ROW_W-1:0] cy;
  assign cx = i_x[COL_W-1:0];
  assign cy = i_y[ROW_W-1:0];

  // Screen-position bits above the glyph cell are not needed here.
  logic unused_xy;
  assign unused_xy = ^{i_x[9:COL_W], i_y[9:ROW_W]};

  // Stage 1 state
  logic              de1_q,     de1_d;
  logic [CHAR_W-1:0] char1_q,   char1_d;
  logic [ATTR_W-1:0] attr1_q,   attr1_d;
  logic              blink1_q,  blink1_d;
  logic              cursor1_q, cursor1_d;
  logic [COL_W-1:0]  cx1_q,     cx1_d;
  logic [ROW_W-1:0]  cy1_q,     cy1_d;
  // Stage 2 state
  logic               de2_q,  de2_d;
  logic               dot2_q, dot2_d;
  logic [COLOR_W-1:0] fg2_q,  fg2_d;
  logic [COLOR_W-1:0] bg2_q,  bg2_d;
  // Stage 3 state
  logic               de3_q,    de3_d;
  logic [COLOR_W-1:0] video3_q, video3_d;
  // Blink timing and palette
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 phase_q, phase_d;
  logic [2*COLOR_W-1:0] pal_q [PAL_N];
  logic [2*COLOR_W-1:0] pal_d [PAL_N];

  // Stage 1: register the incoming pixel and its glyph-cell coordinates.
  always_comb begin
    de1_d     = i_de;
    char1_d   = i_char;
    attr1_d   = i_attr;
    blink1_d  = i_blink;
    cursor1_d = i_cursor;
    cx1_d     = cx;
    cy1_d     = cy;
  end

  // Stage 2: effective dot (blink hides, cursor inverts) and palette lookup.
  // The palette read uses the registered array, so a write on the same edge
  // is seen only by the following pixel.
  always_comb begin
    logic d;
    d = i_rom_dot;
    if (blink1_q && phase_q) d = 1'b0;
    if (cursor1_q && !phase_q && (cy1_q >= CUR_ROW)) d = ~d;
    de2_d  = de1_q;
    dot2_d = d;
    {fg2_d, bg2_d} = pal_q[attr1_q];
  end

  // Stage 3: choose fg/bg and blank outside the display area.
  always_comb begin
    de3_d    = de2_q;
    video3_d = de2_q ? (dot2_q ? fg2_q : bg2_q) : '0;
  end

  // Blink: phase toggles each time BLINK_FRAMES frame pulses have been counted.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_frame) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Palette: single write port, written entry takes the new {fg, bg}.
  always_comb begin
    for (int i = 0; i < PAL_N; i++) begin
      pal_d[i] = pal_q[i];
    end
    if (i_pal_we) pal_d[i_pal_addr] = i_pal_data;
  end

  // All state registers; reset discards in-flight pixels and restores the palette.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de1_q     <= 1'b0;
      char1_q   <= '0;
      attr1_q   <= '0;
      blink1_q  <= 1'b0;
      cursor1_q <= 1'b0;
      cx1_q     <= '0;
      cy1_q     <= '0;
      de2_q     <= 1'b0;
      dot2_q    <= 1'b0;
      fg2_q     <= '0;
      bg2_q     <= '0;
      de3_q     <= 1'b0;
      video3_q  <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else begin
      de1_q     <= de1_d;
      char1_q   <= char1_d;
      attr1_q   <= attr1_d;
      blink1_q  <= blink1_d;
      cursor1_q <= cursor1_d;
      cx1_q     <= cx1_d;
      cy1_q     <= cy1_d;
      de2_q     <= de2_d;
      dot2_q    <= dot2_d;
      fg2_q     <= fg2_d;
      bg2_q     <= bg2_d;
      de3_q     <= de3_d;
      video3_q  <= video3_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  assign o_rom_char = char1_q;
  assign o_rom_row  = cy1_q;
  assign o_rom_col  = cx1_q;
  assign o_video    = video3_q;
  assign o_de       = de3_q;

endmodule

// File: tb/tb_graphics_pipe.sv
// tb_graphics_pipe: directed and randomized checks of graphics_pipe against a
// pixel-level reference model (palette array, frame count, pixel in flight).
module tb_graphics_pipe;

  localparam int BF = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_de;
  logic [9:0] i_x;
  logic [9:0] i_y;
  logic [4:0] i_char;
  logic [1:0] i_attr;
  logic       i_blink;
  logic       i_cursor;
  logic       i_frame;
  logic       i_pal_we;
  logic [1:0] i_pal_addr;
  logic [11:0] i_pal_data;
  logic [4:0] o_rom_char;
  logic [2:0] o_rom_row;
  logic [2:0] o_rom_col;
  logic       i_rom_dot;
  logic [5:0] o_video;
  logic       o_de;

  graphics_pipe #(
    .CHAR_W(5), .ATTR_W(2), .COLOR_W(6), .GLYPH_W(8), .GLYPH_H(8),
    .CURSOR_H(2), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_de(i_de), .i_x(i_x), .i_y(i_y),
    .i_char(i_char), .i_attr(i_attr), .i_blink(i_blink), .i_cursor(i_cursor),
    .i_frame(i_frame), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
    .i_pal_data(i_pal_data), .o_rom_char(o_rom_char), .o_rom_row(o_rom_row),
    .o_rom_col(o_rom_col), .i_rom_dot(i_rom_dot), .o_video(o_video), .o_de(o_de)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       de;
    logic [4:0] ch;
    logic [1:0] attr;
    logic       blink;
    logic       cursor;
    logic [9:0] x;
    logic [9:0] y;
    logic       dot;
  } pix_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [5:0] m_fg [4];
  logic [5:0] m_bg [4];
  int         m_frames;
  pix_t       cur_pix;
  pix_t       p1;
  logic [5:0] e2_video;
  logic       e2_de;
  // Expected outputs after the most recent tick
  logic [5:0] exp_video;
  logic       exp_de;
  logic [4:0] exp_char;
  logic [2:0] exp_row;
  logic [2:0] exp_col;

  function automatic pix_t zero_pix();
    pix_t p;
    p.de = 0; p.ch = 0; p.attr = 0; p.blink = 0; p.cursor = 0;
    p.x = 0; p.y = 0; p.dot = 0;
    return p;
  endfunction

  // Colour a pixel gets, given the palette and frame count it meets at stage 2.
  function automatic logic [5:0] model_video(input pix_t p);
    int   phase;
    logic d;
    phase = (m_frames / BF) % 2;
    d = p.dot;
    if (p.blink && phase == 1) d = 1'b0;
    if (p.cursor && phase == 0 && (p.y % 8) >= 6) d = ~d;
    if (!p.de) return 6'd0;
    return d ? m_fg[p.attr] : m_bg[p.attr];
  endfunction

  task automatic model_reset();
    m_fg[0] = 6'b111111; m_bg[0] = 6'b000000;
    m_fg[1] = 6'b000000; m_bg[1] = 6'b011101;
    m_fg[2] = 6'b000000; m_bg[2] = 6'b110001;
    m_fg[3] = 6'b000000; m_bg[3] = 6'b000000;
    m_frames = 0;
    p1 = zero_pix();
    e2_video = 6'd0;
    e2_de = 1'b0;
  endtask

  task automatic set_pix(input logic de, input logic [1:0] attr, input logic dot,
                         input logic blink, input logic cursor,
                         input logic [9:0] x, input logic [9:0] y, input logic [4:0] ch);
    cur_pix.de = de; cur_pix.attr = attr; cur_pix.dot = dot; cur_pix.blink = blink;
    cur_pix.cursor = cursor; cur_pix.x = x; cur_pix.y = y; cur_pix.ch = ch;
    i_de = de; i_attr = attr; i_blink = blink; i_cursor = cursor;
    i_x = x; i_y = y; i_char = ch;
  endtask

  // One clock: advance DUT and model, leave expected outputs in exp_*.
  task automatic tick();
    logic [5:0] nv;
    logic       nd;
    nv = model_video(p1);
    nd = p1.de;
    @(posedge i_clk);
    #1;
    exp_video = e2_video;
    exp_de    = e2_de;
    e2_video  = nv;
    e2_de     = nd;
    if (i_pal_we) begin
      m_fg[i_pal_addr] = i_pal_data[11:6];
      m_bg[i_pal_addr] = i_pal_data[5:0];
    end
    if (i_frame) m_frames++;
    p1 = cur_pix;
    exp_char = p1.ch;
    exp_row  = 3'(p1.y % 8);
    exp_col  = 3'(p1.x % 8);
    i_rom_dot = p1.dot;
    i_pal_we  = 1'b0;
    i_frame   = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_video !== 6'd0 || o_de !== 1'b0 || o_rom_char !== 5'd0 ||
        o_rom_row !== 3'd0 || o_rom_col !== 3'd0)
      begin
        n_errors++;
        $display("FAIL reset_async video=%b de=%b rom=%0d/%0d/%0d exp all zero",
                 o_video, o_de, o_rom_char, o_rom_row, o_rom_col);
      end
    model_reset();
    i_rom_dot = 1'b0;
    i_pal_we = 1'b0;
    i_frame = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_pix(1, 2, 0, 0, 0, 10'd0, 10'd0, 5'd0);
    tick();
    set_pix(1, 0, 1, 0, 0, 10'd1, 10'd0, 5'd0);
    tick();
    tick();
    n_checks++;
    if (o_video !== 6'b110001 || o_de !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_default_bg2 video=%b de=%b exp 110001 1", o_video, o_de);
    end
    tick();
    n_checks++;
    if (o_video !== 6'b111111 || o_video !== exp_video) begin
      n_errors++;
      $display("FAIL reset_default_fg0 video=%b exp 111111", o_video);
    end
  endtask

  task automatic test_addressing();
    set_pix(1, 0, 0, 0, 0, 10'd13, 10'd22, 5'd5);
    tick();
    n_checks++;
    if (o_rom_char !== 5'd5 || o_rom_col !== 3'd5 || o_rom_row !== 3'd6) begin
      n_errors++;
      $display("FAIL rom_addr char=%0d col=%0d row=%0d exp 5 5 6",
               o_rom_char, o_rom_col, o_rom_row);
    end
  endtask

  task automatic test_palette_write();
    do_reset();
    set_pix(1, 1, 1, 0, 0, 10'd0, 10'd0, 5'd1);
    tick();
    set_pix(1, 1, 1, 0, 0, 10'd1, 10'd0, 5'd1);
    i_pal_we = 1'b1; i_pal_addr = 2'd1; i_pal_data = {6'b101010, 6'b010101};
    tick();
    tick();
    n_checks++;
    if (o_video !== 6'b000000) begin
      n_errors++;
      $display("FAIL pal_same_cycle video=%b exp 000000", o_video);
    end
    tick();
    n_checks++;
    if (o_video !== 6'b101010) begin
      n_errors++;
      $display("FAIL pal_next_cycle video=%b exp 101010", o_video);
    end
  endtask

  task automatic test_blink();
    do_reset();
    set_pix(1, 0, 1, 1, 0, 10'd0, 10'd0, 5'd2);
    repeat (2) begin i_frame = 1'b1; tick(); end
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b000000) begin
      n_errors++;
      $display("FAIL blink_hidden video=%b exp 000000", o_video);
    end
    repeat (2) begin i_frame = 1'b1; tick(); end
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b111111) begin
      n_errors++;
      $display("FAIL blink_visible video=%b exp 111111", o_video);
    end
  endtask

  task automatic test_cursor();
    do_reset();
    set_pix(1, 0, 0, 0, 1, 10'd3, 10'd7, 5'd3);
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b111111) begin
      n_errors++;
      $display("FAIL cursor_row7 video=%b exp 111111", o_video);
    end
    set_pix(1, 0, 0, 0, 1, 10'd3, 10'd5, 5'd3);
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b000000) begin
      n_errors++;
      $display("FAIL cursor_row5 video=%b exp 000000", o_video);
    end
    set_pix(1, 0, 0, 0, 1, 10'd3, 10'd7, 5'd3);
    repeat (2) begin i_frame = 1'b1; tick(); end
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b000000) begin
      n_errors++;
      $display("FAIL cursor_phase1 video=%b exp 000000", o_video);
    end
  endtask

  task automatic test_de_gating();
    do_reset();
    set_pix(0, 0, 1, 0, 0, 10'd4, 10'd1, 5'd4);
    repeat (3) tick();
    n_checks++;
    if (o_video !== 6'b000000 || o_de !== 1'b0) begin
      n_errors++;
      $display("FAIL de_gate video=%b de=%b exp 000000 0", o_video, o_de);
    end
    n_checks++;
    if (o_rom_char !== 5'd4 || o_rom_col !== 3'd4 || o_rom_row !== 3'd1) begin
      n_errors++;
      $display("FAIL de_gate_rom char=%0d col=%0d row=%0d exp 4 4 1",
               o_rom_char, o_rom_col, o_rom_row);
    end
  endtask

  task automatic test_reset_midstream();
    set_pix(1, 0, 1, 0, 0, 10'd0, 10'd0, 5'd0);
    i_pal_we = 1'b1; i_pal_addr = 2'd0; i_pal_data = {6'b000111, 6'b000011};
    tick();
    repeat (2) tick();
    do_reset();
    set_pix(1, 0, 1, 0, 0, 10'd0, 10'd0, 5'd0);
    tick();
    n_checks++;
    if (o_de !== 1'b0 || o_video !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_flush video=%b de=%b exp 000000 0", o_video, o_de);
    end
    repeat (2) tick();
    n_checks++;
    if (o_video !== 6'b111111 || o_de !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_pal_default video=%b de=%b exp 111111 1", o_video, o_de);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_pix(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 10'($urandom_range(0, 639)),
              10'($urandom_range(0, 479)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 9) == 0) begin
        i_pal_we = 1'b1;
        i_pal_addr = 2'($urandom_range(0, 3));
        i_pal_data = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 5) == 0) i_frame = 1'b1;
      tick();
      n_checks++;
      if (o_video !== exp_video || o_de !== exp_de) begin
        n_errors++;
        $display("FAIL random_video cycle=%0d video=%b de=%b exp %b %b",
                 i, o_video, o_de, exp_video, exp_de);
      end
      n_checks++;
      if (o_rom_char !== exp_char || o_rom_row !== exp_row || o_rom_col !== exp_col) begin
        n_errors++;
        $display("FAIL random_rom cycle=%0d rom=%0d/%0d/%0d exp %0d/%0d/%0d",
                 i, o_rom_char, o_rom_row, o_rom_col, exp_char, exp_row, exp_col);
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_rom_dot = 1'b0;
    i_frame = 1'b0;
    i_pal_we = 1'b0;
    i_pal_addr = 2'd0;
    i_pal_data = 12'd0;
    model_reset();
    cur_pix = zero_pix();
    set_pix(0, 0, 0, 0, 0, 10'd0, 10'd0, 5'd0);
    @(negedge i_clk);
    test_reset();
    test_addressing();
    test_palette_write();
    test_blink();
    test_cursor();
    test_de_gating();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/graphics_pipe.md
Name: graphics_pipe

Overview:
Pipelined, parametrised text-mode pixel renderer. Per pixel it takes a character code, an attribute index and screen x/y, drives a synchronous external font ROM, and produces a COLOR_W-bit video word from a runtime-writable fg/bg palette. It adds frame-driven blink and an underline cursor. It sits between the character/attribute fetch and the video DAC/output register.

Parameters:
CHAR_W, 5, character code width
ATTR_W, 2, attribute (palette index) width; palette has 2**ATTR_W entries
COLOR_W, 6, video word width
GLYPH_W, 8, glyph width in pixels (power of two, >=2)
GLYPH_H, 8, glyph height in pixels (power of two, >=2)
CURSOR_H, 2, cursor underline height in rows (1..GLYPH_H)
BLINK_FRAMES, 16, frames per blink half-period (>=1)

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_de  in  1  display enable for this pixel
i_x  in  10  pixel x
i_y  in  10  pixel y
i_char  in  CHAR_W  character code
i_attr  in  ATTR_W  palette index
i_blink  in  1  cell blinks
i_cursor  in  1  cell is cursor cell
i_frame  in  1  one-cycle pulse per frame
i_pal_we  in  1  palette write strobe
i_pal_addr  in  ATTR_W  palette entry
i_pal_data  in  2*COLOR_W  {fg,bg}
o_rom_char  out  CHAR_W  font ROM char
o_rom_row  out  log2(GLYPH_H)  font ROM row
o_rom_col  out  log2(GLYPH_W)  font ROM column
i_rom_dot  in  1  font ROM dot, valid one cycle after address
o_video  out  COLOR_W  pixel colour
o_de  out  1  delayed display enable

Behaviour:
- Reset (async assert, sync release): all pipeline registers 0; o_video=0, o_de=0, o_rom_*=0; blink counter=0, blink phase=0 (visible); palette to defaults.
- Palette defaults, fg/bg constants LSB-aligned (truncated/zero-extended to COLOR_W): e0 fg=111111 bg=000000; e1 fg=000000 bg=011101; e2 fg=000000 bg=110001; e3 fg=000000 bg=000000; entries >=4 fg=all ones bg=0.
- Stage 1 (clock edge N): register i_de, i_char, i_attr, i_blink, i_cursor, cx=i_x mod GLYPH_W, cy=i_y mod GLYPH_H. o_rom_char/row/col driven directly from stage-1 regs.
- Stage 2 (edge N+1): capture i_rom_dot with stage-1 sidebands; read palette entry for attr.
- Stage 3 (edge N+2): o_video, o_de registered. Total latency 3 cycles, throughput 1 pixel/cycle, no stalls.
- Effective dot: d=i_rom_dot; if blink and phase=1 then d=0; if cursor and phase=0 and cy>=GLYPH_H-CURSOR_H then d=~d.
- o_video = de ? (d ? fg : bg) : 0.
- Palette write: on edge with i_pal_we, entry i_pal_addr <= i_pal_data. Stage-2 read in same cycle as write to same entry returns old value; new value visible from next cycle.
- Blink: on each i_frame, counter increments; at BLINK_FRAMES-1 it wraps to 0 and phase toggles. BLINK_FRAMES=1 toggles every frame. i_frame independent of pixel pipeline; phase change applies to pixels at stage 2 from next edge.
- i_de=0: pipeline still advances; ROM still addressed; output forced 0.
- Reset mid-frame: in-flight pixels discarded, first valid output 3 cycles after release.

Test Plan:
- Reset defaults: release reset, drive de=1, attr=2, rom_dot=0 -> o_video=110001 at edge 3, o_de=1; attr=0, dot=1 -> 111111.
- Addressing: x=13, y=22, char=5 -> o_rom_char=5, o_rom_col=5, o_rom_row=6 one edge after sampling.
- Palette write: write e1={101010,010101}; same-cycle pixel attr=1 dot=1 -> 000000; next pixel -> 101010.
- Blink: BLINK_FRAMES=2, i_blink=1, dot=1, attr=0: after 2 i_frame pulses -> 000000; after 4 -> 111111.
- Cursor: i_cursor=1, dot=0, attr=0, y=7 -> 111111; y=5 -> 000000; phase=1 -> 000000.
- De gating/reset: de=0 with dot=1 -> 000000; assert reset mid-stream -> o_video, o_de 0 immediately, palette back to defaults.
